// File: rtl/snn_spike_dispatcher_if.sv
// snn_spike_dispatcher_if: spike input, Wishbone read master and synapse output channel of the dispatcher
// Ports (dispatcher view, modport master):
//   spike_*  : valid/ready input of axon spike events
//   m_*      : Wishbone classic read master toward the synapse matrix
//   syn_*    : valid/ready output of {axon, vector, err} toward the integrator
// modport slave is the environment view (spike source, synapse matrix, integrator).
interface snn_spike_dispatcher_if #(parameter int AXON_W = 8);
  logic spike_valid_i;
  logic [AXON_W-1:0] spike_axon_i;
  logic spike_ready_o;
  logic m_cyc_o;
  logic m_stb_o;
  logic m_we_o;
  logic [3:0] m_sel_o;
  logic [31:0] m_adr_o;
  logic [31:0] m_dat_i;
  logic m_ack_i;
  logic syn_valid_o;
  logic syn_ready_i;
  logic [AXON_W-1:0] syn_axon_o;
  logic [15:0] syn_vec_o;
  logic syn_err_o;
  modport master(
    input spike_valid_i, spike_axon_i, m_dat_i, m_ack_i, syn_ready_i,
    output spike_ready_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o,
    output syn_valid_o, syn_axon_o, syn_vec_o, syn_err_o
  );
  modport slave(
    output spike_valid_i, spike_axon_i, m_dat_i, m_ack_i, syn_ready_i,
    input spike_ready_o, m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o,
    input syn_valid_o, syn_axon_o, syn_vec_o, syn_err_o
  );
endinterface

// File: rtl/snn_spike_dispatcher.sv
// snn_spike_dispatcher: queues axon spikes, runs one Wishbone read per spike, emits {axon, synapse vector}
// Ports:
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   bus (master)       : spike input, Wishbone read master, synapse output channel
//   busy_o             : sequencer active or spikes queued
//   stat_spikes_o, stat_timeouts_o : dispatch / timeout counters, only with SNN_DISPATCH_STATS_EN defined
module snn_spike_dispatcher #(
  parameter int FIFO_DEPTH = 4,
  parameter int AXON_W = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input logic wb_clk_i,
  input logic wb_rst_i,
  snn_spike_dispatcher_if.master bus,
  output logic busy_o
`ifdef SNN_DISPATCH_STATS_EN
  ,
  output logic [15:0] stat_spikes_o,
  output logic [15:0] stat_timeouts_o
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, BUS, OUT} state_t;
  state_t state, state_n;
  logic [AXON_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr, rd;
  logic [PW:0] cnt, cnt_n;
  logic push, pop, ack, tmo, empty, ne_d, avail;
  logic [7:0] timer;
  logic cyc, valid, err;
  logic [31:0] adr;
  logic [AXON_W-1:0] axon;
  logic [15:0] vec;
  assign empty = cnt == '0;
  assign bus.spike_ready_o = cnt != (PW+1)'(FIFO_DEPTH);
  assign push = bus.spike_valid_i && bus.spike_ready_o;
  assign cnt_n = cnt + (PW+1)'(push) - (PW+1)'(pop);
  // A freshly written entry into an empty queue is offered to the sequencer one
  // cycle later, so the head read always has a full cycle after the write.
  assign avail = !empty && ne_d;
  assign bus.m_cyc_o = cyc;
  assign bus.m_stb_o = cyc;
  assign bus.m_we_o = 1'b0;
  assign bus.m_sel_o = 4'hF;
  assign bus.m_adr_o = adr;
  assign bus.syn_valid_o = valid;
  assign bus.syn_axon_o = axon;
  assign bus.syn_vec_o = vec;
  assign bus.syn_err_o = err;
  always_comb begin
    state_n = state;
    pop = 1'b0;
    ack = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: begin
        pop = avail;
        state_n = avail ? BUS : IDLE;
      end
      BUS: begin
        ack = bus.m_ack_i;
        tmo = !bus.m_ack_i && timer == TIMEOUT - 8'd1;
        state_n = (bus.m_ack_i || tmo) ? OUT : BUS;
      end
      OUT: if (bus.syn_ready_i) begin
        pop = avail;
        state_n = avail ? BUS : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) if (push) mem[wr] <= bus.spike_axon_i;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      wr <= '0;
      rd <= '0;
      cnt <= '0;
      ne_d <= 1'b0;
      timer <= '0;
      cyc <= 1'b0;
      adr <= BASE_ADDR;
      axon <= '0;
      vec <= '0;
      err <= 1'b0;
      valid <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ne_d <= !empty;
      cyc <= state_n == BUS;
      valid <= state_n == OUT;
      busy_o <= state_n != IDLE || cnt_n != '0;
      if (push) wr <= wr + PW'(1);
      if (pop) begin
        rd <= rd + PW'(1);
        adr <= BASE_ADDR + 32'({mem[rd], 2'b00});
        axon <= mem[rd];
        timer <= '0;
      end else if (state == BUS) timer <= timer + 8'd1;
      if (ack) begin
        vec <= bus.m_dat_i[15:0];
        err <= 1'b0;
      end
      if (tmo) begin
        vec <= '0;
        err <= 1'b1;
      end
    end
  end
`ifdef SNN_DISPATCH_STATS_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stat_spikes_o <= '0;
      stat_timeouts_o <= '0;
    end else if (state == OUT && bus.syn_ready_i) begin
      stat_spikes_o <= stat_spikes_o + 16'(stat_spikes_o != 16'hFFFF);
      stat_timeouts_o <= stat_timeouts_o + 16'(err && stat_timeouts_o != 16'hFFFF);
    end
  end
`endif
endmodule

// File: tb/tb_snn_spike_dispatcher.sv
// tb_snn_spike_dispatcher: directed vector bench for snn_spike_dispatcher (TIMEOUT=10)
module tb_snn_spike_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic auto_ack = 1'b0;
  logic ack_auto = 1'b0;
  logic ack_man = 1'b0;
  logic [31:0] dat_man = '0;
  logic [31:0] dat_auto;
  int total = 0;
  int bad = 0;
`ifdef SNN_DISPATCH_STATS_EN
  logic [15:0] ss, st;
`endif
  typedef struct {
    logic [7:0] axon;
    logic [31:0] dat;
    int d;
    logic late;
    logic [31:0] adr;
    logic [15:0] vec;
    logic err;
  } vec_t;
  vec_t tv[5];
  snn_spike_dispatcher_if #(.AXON_W(8)) bus();
  snn_spike_dispatcher #(.TIMEOUT(8'd10)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus(bus),
    .busy_o(busy)
`ifdef SNN_DISPATCH_STATS_EN
    ,
    .stat_spikes_o(ss),
    .stat_timeouts_o(st)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) ack_auto <= bus.m_cyc_o && !ack_auto;
  assign dat_auto = {16'h0, 8'h5A, bus.m_adr_o[9:2]};
  assign bus.m_ack_i = auto_ack ? ack_auto : ack_man;
  assign bus.m_dat_i = auto_ack ? dat_auto : dat_man;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, act, exp);
    end
  endtask
  task automatic tick();
    logic acc;
    acc = bus.spike_valid_i && bus.spike_ready_o;
    @(posedge clk);
    #1;
    if (acc) bus.spike_valid_i = 1'b0;
  endtask
  task automatic run_vec(input vec_t v);
    int n;
    int c;
    bus.spike_axon_i = v.axon;
    bus.spike_valid_i = 1'b1;
    tick();
    n = 0;
    while (!bus.m_cyc_o && n < 20) begin
      tick();
      n++;
    end
    chk("push_to_cyc", n, 2);
    chk("adr", bus.m_adr_o, v.adr);
    chk("stb_eq_cyc", bus.m_stb_o, bus.m_cyc_o);
    c = 0;
    while (bus.m_cyc_o && c < 300) begin
      c++;
      ack_man = v.d != 0 && c == v.d + 1;
      dat_man = v.dat;
      tick();
    end
    ack_man = 1'b0;
    chk("cyc_cycles", c, v.d == 0 ? 10 : v.d + 1);
    chk("valid", bus.syn_valid_o, 1'b1);
    chk("vec", bus.syn_vec_o, v.vec);
    chk("axon", bus.syn_axon_o, v.axon);
    chk("err", bus.syn_err_o, v.err);
    if (v.late) begin
      tick();
      tick();
      ack_man = 1'b1;
      dat_man = 32'h0000_BEEF;
      tick();
      ack_man = 1'b0;
      chk("late_vec", bus.syn_vec_o, 16'h0);
      chk("late_err", bus.syn_err_o, 1'b1);
      chk("late_valid", bus.syn_valid_o, 1'b1);
      chk("late_cyc", bus.m_cyc_o, 1'b0);
    end
    bus.syn_ready_i = 1'b1;
    tick();
    bus.syn_ready_i = 1'b0;
    chk("valid_after_hs", bus.syn_valid_o, 1'b0);
    chk("busy_after_hs", busy, 1'b0);
  endtask
  initial begin
    int n;
    tv[0] = '{8'h05, 32'h0000_A5C3, 1, 1'b0, 32'h3000_0014, 16'hA5C3, 1'b0};
    tv[1] = '{8'hFF, 32'hFFFF_1234, 3, 1'b0, 32'h3000_03FC, 16'h1234, 1'b0};
    tv[2] = '{8'h00, 32'h0000_7777, 0, 1'b1, 32'h3000_0000, 16'h0000, 1'b1};
    tv[3] = '{8'h80, 32'h0000_FFFF, 9, 1'b0, 32'h3000_0200, 16'hFFFF, 1'b0};
    tv[4] = '{8'h3C, 32'h0000_8001, 2, 1'b0, 32'h3000_00F0, 16'h8001, 1'b0};
    bus.spike_valid_i = 1'b0;
    bus.spike_axon_i = '0;
    bus.syn_ready_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_cyc", bus.m_cyc_o, 1'b0);
    chk("rst_adr", bus.m_adr_o, 32'h3000_0000);
    chk("rst_valid", bus.syn_valid_o, 1'b0);
    chk("rst_ready", bus.spike_ready_o, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("we", bus.m_we_o, 1'b0);
    chk("sel", bus.m_sel_o, 4'hF);
    for (int i = 0; i < 5; i++) run_vec(tv[i]);
    auto_ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      bus.spike_axon_i = 8'(i);
      bus.spike_valid_i = 1'b1;
      tick();
      if (i == 4) chk("ready_after_4", bus.spike_ready_o, 1'b1);
    end
    chk("ready_full", bus.spike_ready_o, 1'b0);
    bus.spike_axon_i = 8'd6;
    bus.spike_valid_i = 1'b1;
    repeat (3) tick();
    chk("ready_hold_full", bus.spike_ready_o, 1'b0);
    chk("out_held", bus.syn_valid_o, 1'b1);
    bus.syn_ready_i = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      n = 0;
      while (!bus.syn_valid_o && n < 30) begin
        tick();
        n++;
      end
      chk("fifo_valid", bus.syn_valid_o, 1'b1);
      chk("fifo_axon", bus.syn_axon_o, j);
      chk("fifo_vec", bus.syn_vec_o, 16'h5A00 | 16'(j));
      tick();
      if (j < 6) chk("b2b_cyc", bus.m_cyc_o, 1'b1);
    end
    bus.syn_ready_i = 1'b0;
    chk("drain_cyc", bus.m_cyc_o, 1'b0);
    chk("drain_busy", busy, 1'b0);
    tick();
    auto_ack = 1'b0;
    bus.spike_axon_i = 8'h07;
    bus.spike_valid_i = 1'b1;
    tick();
    bus.spike_axon_i = 8'h09;
    bus.spike_valid_i = 1'b1;
    tick();
    n = 0;
    while (!bus.m_cyc_o && n < 20) begin
      tick();
      n++;
    end
    chk("pre_rst_cyc", bus.m_cyc_o, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cyc", bus.m_cyc_o, 1'b0);
    chk("mid_rst_stb", bus.m_stb_o, 1'b0);
    chk("mid_rst_adr", bus.m_adr_o, 32'h3000_0000);
    chk("mid_rst_valid", bus.syn_valid_o, 1'b0);
    chk("mid_rst_vec", bus.syn_vec_o, 16'h0);
    chk("mid_rst_axon", bus.syn_axon_o, 8'h0);
    chk("mid_rst_err", bus.syn_err_o, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", bus.spike_ready_o, 1'b1);
`ifdef SNN_DISPATCH_STATS_EN
    chk("rst_stat_spk", ss, 16'd0);
    chk("rst_stat_tmo", st, 16'd0);
`endif
    repeat (4) tick();
    chk("queue_lost_cyc", bus.m_cyc_o, 1'b0);
    chk("queue_lost_busy", busy, 1'b0);
    run_vec(tv[0]);
    run_vec(tv[1]);
    run_vec(tv[2]);
    run_vec(tv[4]);
`ifdef SNN_DISPATCH_STATS_EN
    chk("stat_spikes", ss, 16'd4);
    chk("stat_timeouts", st, 16'd1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
